// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Two-client round-robin arbiter and sequencer for the shared 32-bit ALU.
//   A request accepted in IDLE loads the winner's operands and opcode into
//   the ALU input registers and pulses GNT. The next edge captures the ALU
//   result and flags, tags them with the owner ID and pulses DONE. The block
//   then returns to IDLE, so it completes at most one operation every two
//   cycles.
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   REQ0/REQ1             client requests (held until GNT seen)
//   A0,B0,OP0 / A1,B1,OP1 per-client operands and opcode
//   GNT0/GNT1             one-cycle grant pulse (operands captured)
//   DONE0/DONE1           one-cycle completion pulse (F_OUT/flags valid)
//   F_OUT,ZF_OUT,OF_OUT   captured result and flags, held until next capture
//   RES_ID                client that owns F_OUT
//   BUSY                  high while an operation is in flight
//   ALU_A,ALU_B,ALU_OP    registered operands/opcode to the ALU
//   ALU_F,ALU_ZF,ALU_OF   combinational ALU result and flags
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic [31:0] A0,
  input  logic [31:0] B0,
  input  logic [31:0] A1,
  input  logic [31:0] B1,
  input  logic [2:0]  OP0,
  input  logic [2:0]  OP1,
  output logic        GNT0,
  output logic        GNT1,
  output logic        DONE0,
  output logic        DONE1,
  output logic [31:0] F_OUT,
  output logic        ZF_OUT,
  output logic        OF_OUT,
  output logic        RES_ID,
  output logic        BUSY,
  output logic [31:0] ALU_A,
  output logic [31:0] ALU_B,
  output logic [2:0]  ALU_OP,
  input  logic [31:0] ALU_F,
  input  logic        ALU_ZF,
  input  logic        ALU_OF
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic any_req;
  logic winner;
  logic last_gnt;   // ID granted most recently; resets to 1 so client 0 wins the first tie
  logic owner_p1;   // ID of the operation currently in the ALU

  always_comb begin
    any_req = REQ0 | REQ1;
    // On a tie the client that was not granted last wins; otherwise the
    // lone requester wins regardless of history.
    winner  = (REQ0 & REQ1) ? ~last_gnt : REQ1;
  end

  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if (any_req) state_nxt = EXEC;
    end else begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign BUSY = (state == EXEC);

  always_ff @(posedge clk) begin
    if (rst) begin
      GNT0     <= 1'b0;
      GNT1     <= 1'b0;
      DONE0    <= 1'b0;
      DONE1    <= 1'b0;
      F_OUT    <= 32'd0;
      ZF_OUT   <= 1'b0;
      OF_OUT   <= 1'b0;
      RES_ID   <= 1'b0;
      ALU_A    <= 32'd0;
      ALU_B    <= 32'd0;
      ALU_OP   <= 3'd0;
      last_gnt <= 1'b1;
      owner_p1 <= 1'b0;
    end else begin
      GNT0  <= 1'b0;
      GNT1  <= 1'b0;
      DONE0 <= 1'b0;
      DONE1 <= 1'b0;
      if (state == IDLE) begin
        // Stage 1: grant and load the ALU input registers
        if (any_req) begin
          ALU_A    <= winner ? A1  : A0;
          ALU_B    <= winner ? B1  : B0;
          ALU_OP   <= winner ? OP1 : OP0;
          GNT0     <= ~winner;
          GNT1     <= winner;
          last_gnt <= winner;
          owner_p1 <= winner;
        end
      end else begin
        // Stage 2: capture the ALU result for the owner
        F_OUT  <= ALU_F;
        ZF_OUT <= ALU_ZF;
        OF_OUT <= ALU_OF;
        RES_ID <= owner_p1;
        DONE0  <= ~owner_p1;
        DONE1  <= owner_p1;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        REQ0, REQ1;
  logic [31:0] A0, B0, A1, B1;
  logic [2:0]  OP0, OP1;
  logic        GNT0, GNT1, DONE0, DONE1;
  logic [31:0] F_OUT;
  logic        ZF_OUT, OF_OUT, RES_ID, BUSY;
  logic [31:0] ALU_A, ALU_B;
  logic [2:0]  ALU_OP;
  logic [31:0] ALU_F;
  logic        ALU_ZF, ALU_OF;

  always #5 clk = ~clk;

  // ALU stub: F = A + B, ZF = (F == 0), OF = signed overflow
  assign ALU_F  = ALU_A + ALU_B;
  assign ALU_ZF = (ALU_F == 32'd0);
  assign ALU_OF = (ALU_A[31] == ALU_B[31]) && (ALU_F[31] != ALU_A[31]);

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .REQ0(REQ0), .REQ1(REQ1),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1),
    .OP0(OP0), .OP1(OP1),
    .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
    .F_OUT(F_OUT), .ZF_OUT(ZF_OUT), .OF_OUT(OF_OUT),
    .RES_ID(RES_ID), .BUSY(BUSY),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OP(ALU_OP),
    .ALU_F(ALU_F), .ALU_ZF(ALU_ZF), .ALU_OF(ALU_OF)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: transaction view of the arbiter
  logic        m_inflight;     // an accepted operation awaits its result
  int          m_owner;        // client of the in-flight operation
  int          m_prev;         // client granted most recently
  logic [31:0] m_opa, m_opb;
  logic [2:0]  m_op;
  logic        m_gnt[2];
  logic        m_done[2];
  logic [31:0] m_f;
  logic        m_zf, m_of;
  int          m_id;

  int seq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Result of a + b computed with wide signed arithmetic
  function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] f, output logic zf, output logic of);
    longint s;
    s  = longint'($signed(a)) + longint'($signed(b));
    f  = s[31:0];
    zf = (f == 32'd0);
    of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic model_reset();
    m_inflight = 1'b0; m_owner = 0; m_prev = 1;
    m_opa = '0; m_opb = '0; m_op = '0;
    m_gnt[0] = 0; m_gnt[1] = 0; m_done[0] = 0; m_done[1] = 0;
    m_f = '0; m_zf = 0; m_of = 0; m_id = 0;
  endtask

  // Advance the model by one clock edge using the inputs presented now
  task automatic model_edge();
    int w;
    if (rst) begin
      model_reset();
      return;
    end
    m_gnt[0] = 0; m_gnt[1] = 0; m_done[0] = 0; m_done[1] = 0;
    if (m_inflight) begin
      ref_alu(m_opa, m_opb, m_f, m_zf, m_of);
      m_id = m_owner;
      m_done[m_owner] = 1;
      m_inflight = 0;
    end else if (REQ0 || REQ1) begin
      if (REQ0 && REQ1) w = 1 - m_prev;
      else              w = REQ1 ? 1 : 0;
      m_opa = (w == 1) ? A1 : A0;
      m_opb = (w == 1) ? B1 : B0;
      m_op  = (w == 1) ? OP1 : OP0;
      m_gnt[w] = 1;
      m_prev = w; m_owner = w; m_inflight = 1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk); #1;
    if (GNT0 === 1'b1) seq.push_back(0);
    if (GNT1 === 1'b1) seq.push_back(1);
    check("GNT0",   GNT0,   m_gnt[0]);
    check("GNT1",   GNT1,   m_gnt[1]);
    check("DONE0",  DONE0,  m_done[0]);
    check("DONE1",  DONE1,  m_done[1]);
    check("BUSY",   BUSY,   m_inflight);
    check("F_OUT",  F_OUT,  m_f);
    check("ZF_OUT", ZF_OUT, m_zf);
    check("OF_OUT", OF_OUT, m_of);
    check("RES_ID", RES_ID, 32'(m_id));
    check("ALU_A",  ALU_A,  m_opa);
    check("ALU_B",  ALU_B,  m_opb);
    check("ALU_OP", ALU_OP, m_op);
  endtask

  initial begin
    rst = 1; REQ0 = 0; REQ1 = 0;
    A0 = 0; B0 = 0; A1 = 0; B1 = 0; OP0 = 0; OP1 = 0;
    model_reset();
    #1;
    tick(); tick();
    rst = 0;
    tick();

    // Single request from client 0
    REQ0 = 1; A0 = 32'd5; B0 = 32'd7; OP0 = 3'd2;
    tick();
    check("single_gnt0", GNT0, 1);
    REQ0 = 0;
    tick();
    check("single_done0", DONE0, 1);
    check("single_f", F_OUT, 32'd12);
    check("single_id", RES_ID, 0);

    // Simultaneous held requests after reset: 0,1,0,1
    rst = 1; tick(); rst = 0;
    seq.delete();
    REQ0 = 1; REQ1 = 1;
    A0 = $urandom; B0 = $urandom; OP0 = 3'd1;
    A1 = $urandom; B1 = $urandom; OP1 = 3'd6;
    for (int i = 0; i < 8; i++) tick();
    REQ0 = 0; REQ1 = 0;
    tick();
    check("tie_count", seq.size(), 4);
    if (seq.size() == 4) begin
      check("tie_order0", seq[0], 0);
      check("tie_order1", seq[1], 1);
      check("tie_order2", seq[2], 0);
      check("tie_order3", seq[3], 1);
    end

    // Flags from client 1
    REQ1 = 1; A1 = 32'h7FFFFFFF; B1 = 32'd1;
    tick(); REQ1 = 0; tick();
    check("ovf_f", F_OUT, 32'h80000000);
    check("ovf_of", OF_OUT, 1);
    check("ovf_id", RES_ID, 1);
    REQ1 = 1; A1 = 32'hFFFFFFFF; B1 = 32'd1;
    tick(); REQ1 = 0; tick();
    check("zero_f", F_OUT, 32'd0);
    check("zero_zf", ZF_OUT, 1);
    check("zero_of", OF_OUT, 0);

    // Idle hold for 10 cycles
    for (int i = 0; i < 10; i++) tick();
    check("hold_zf", ZF_OUT, 1);

    // Reset during EXEC drops the operation
    REQ0 = 1; A0 = 32'd100; B0 = 32'd1;
    tick(); REQ0 = 0;
    rst = 1; tick(); rst = 0;
    check("rst_done0", DONE0, 0);
    check("rst_f", F_OUT, 0);
    seq.delete();
    REQ0 = 1; REQ1 = 1;
    tick();
    REQ0 = 0; REQ1 = 0;
    tick();
    check("rst_first", (seq.size() > 0) ? seq[0] : 9, 0);

    // Back-to-back client 1 with opcode changes between grants
    seq.delete();
    REQ1 = 1; A1 = 32'd3; B1 = 32'd4; OP1 = 3'd1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (m_gnt[1]) OP1 = OP1 + 3'd2;
    end
    REQ1 = 0;
    tick();
    check("b2b_count", seq.size(), 3);
    check("b2b_lastop", ALU_OP, 3'd5);

    // Randomised traffic following the client handshake
    for (int i = 0; i < 300; i++) begin
      if (!REQ0 && $urandom_range(0, 2) == 0) begin
        REQ0 = 1; A0 = $urandom; B0 = $urandom; OP0 = 3'($urandom);
      end
      if (!REQ1 && $urandom_range(0, 2) == 0) begin
        REQ1 = 1; A1 = $urandom; B1 = $urandom; OP1 = 3'($urandom);
        if ($urandom_range(0, 7) == 0) B1 = -A1;
      end
      rst = ($urandom_range(0, 49) == 0);
      tick();
      rst = 0;
      if (m_gnt[0]) REQ0 = 0;
      if (m_gnt[1]) REQ1 = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
